// File: rtl/matrix_stream_loader_if.sv
// Stream-in / inverter-out bundle for matrix_stream_loader.
// The slave modport is the loader's view; master is the feeder/inverter side.
interface matrix_stream_loader_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [3:0]        order;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inv_rst;
  logic [3:0]        inv_order;
  logic [DATA_W-1:0] inv_data;
  logic              inv_ready;
  logic              busy;
  logic              done;
  logic              err_order;
  logic              timeout;

  modport slave (
    input  start, order, in_valid, in_data, inv_ready,
    output in_ready, inv_rst, inv_order, inv_data, busy, done, err_order, timeout
  );

  modport master (
    output start, order, in_valid, in_data, inv_ready,
    input  in_ready, inv_rst, inv_order, inv_data, busy, done, err_order, timeout
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Buffers one order x order matrix from a valid/ready stream, then drives the inverter load sequence.
// Optional WAIT watchdog enabled by defining MATRIX_LOADER_TIMEOUT_EN.
module matrix_stream_loader #(
  parameter int DATA_W         = 16,
  parameter int MAX_ORDER      = 15,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,   // active low, asynchronous
  matrix_stream_loader_if.slave  ld_if
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RESET, S_PRIME, S_STREAM, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          order_q, order_d;
  logic [ADDR_W-1:0]   k_q, k_d, t_last, rd_addr;
  logic                inv_rst_q, inv_rst_d;
  logic                done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   inv_data_q;
  logic                wr_en, rd_en, illegal, wait_expired, tmo;
  logic [DATA_W-1:0]   mem [MAX_ORDER*MAX_ORDER];

  assign t_last  = ADDR_W'({4'd0, order_q} * {4'd0, order_q}) - ADDR_W'(1);
  assign illegal = (ld_if.order == 4'd0) || (32'(ld_if.order) > MAX_ORDER);

`ifdef MATRIX_LOADER_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WC_W-1:0] wcnt_q;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 wcnt_q <= '0;
    else if (state_q != S_WAIT) wcnt_q <= '0;
    else                        wcnt_q <= wcnt_q + WC_W'(1);
  end
  assign wait_expired = (wcnt_q == WC_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_expired = 1'b0;
`endif

  assign tmo = (state_q == S_WAIT) && !ld_if.inv_ready && wait_expired;

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    k_d     = k_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = k_q + ADDR_W'(1);
    unique case (state_q)
      S_IDLE: if (ld_if.start) begin
        if (illegal) err_d = 1'b1;
        else begin
          order_d = ld_if.order;
          k_d     = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: if (ld_if.in_valid) begin
        wr_en = 1'b1;
        if (k_q == t_last) begin
          k_d     = '0;
          state_d = S_RESET;
        end else k_d = k_q + ADDR_W'(1);
      end
      S_RESET: if (k_q == ADDR_W'(1)) begin
        k_d     = '0;
        state_d = S_PRIME;
      end else k_d = k_q + ADDR_W'(1);
      S_PRIME: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        k_d     = '0;
        state_d = S_STREAM;
      end
      // k is the index currently on inv_data; the read for k+1 is issued now.
      S_STREAM: if (k_q == t_last) begin
        k_d     = '0;
        state_d = S_WAIT;
      end else begin
        rd_en = 1'b1;
        k_d   = k_q + ADDR_W'(1);
      end
      S_WAIT: if (ld_if.inv_ready) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (wait_expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign inv_rst_d = (state_d != S_RESET) && !tmo;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      order_q    <= 4'd1;
      k_q        <= '0;
      inv_rst_q  <= 1'b0;
      inv_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      k_q       <= k_d;
      inv_rst_q <= inv_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (rd_en) inv_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[k_q] <= ld_if.in_data;
  end

  assign ld_if.in_ready  = (state_q == S_FILL);
  assign ld_if.busy      = (state_q != S_IDLE);
  assign ld_if.inv_rst   = inv_rst_q;
  assign ld_if.inv_order = order_q;
  assign ld_if.inv_data  = inv_data_q;
  assign ld_if.done      = done_q;
  assign ld_if.err_order = err_q;
  assign ld_if.timeout   = tmo;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader; streamed elements are queued on input and checked on inv_data.
module tb_matrix_stream_loader;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] src [225];
  logic [15:0] exp_q [$];

  matrix_stream_loader_if #(.DATA_W(16)) ld_if ();

  matrix_stream_loader #(
    .DATA_W(16), .MAX_ORDER(15), .ADDR_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ld_if (ld_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inv_rst"},   32'(ld_if.inv_rst),   0);
    chk({tag, "_in_ready"},  32'(ld_if.in_ready),  0);
    chk({tag, "_busy"},      32'(ld_if.busy),      0);
    chk({tag, "_done"},      32'(ld_if.done),      0);
    chk({tag, "_err"},       32'(ld_if.err_order), 0);
    chk({tag, "_timeout"},   32'(ld_if.timeout),   0);
    chk({tag, "_inv_data"},  32'(ld_if.inv_data),  0);
    chk({tag, "_inv_order"}, 32'(ld_if.inv_order), 1);
  endtask

  // rdy_dly < 0 : never raise inv_ready (watchdog path); abort_at >= 0 : reset during that STREAM element.
  task automatic run_load(input int ord, input bit toggle, input int rdy_dly,
                          input int abort_at, input bit poke);
    int t, n, fc;
    logic [15:0] e, last;
    t = ord * ord; n = 0; fc = 0;
    cyc(); ld_if.start = 1'b1; ld_if.order = 4'(ord);
    cyc(); ld_if.start = 1'b0;
    while (n < t) begin
      ld_if.in_valid = !(toggle && (fc % 2 == 1));
      ld_if.in_data  = ld_if.in_valid ? src[n] : 16'hBAD0;
      if (ld_if.in_valid) begin
        exp_q.push_back(src[n]);
        n++;
      end
      mid(); chk("fill_in_ready", 32'(ld_if.in_ready), 1);
      cyc(); fc++;
    end
    ld_if.in_valid = 1'b0;
    mid(); chk("reset1_inv_rst", 32'(ld_if.inv_rst), 0);
           chk("reset1_in_ready", 32'(ld_if.in_ready), 0);
           chk("reset1_inv_order", 32'(ld_if.inv_order), 32'(ord));
    cyc(); mid(); chk("reset2_inv_rst", 32'(ld_if.inv_rst), 0);
    cyc(); mid(); chk("prime_inv_rst", 32'(ld_if.inv_rst), 1);
                  chk("prime_busy", 32'(ld_if.busy), 1);
    last = src[t-1];
    for (int j = 0; j < t; j++) begin
      cyc();
      if (j == abort_at) begin
        rst = 1'b0;
        #1;
        chk_reset_vals("abort");
        exp_q.delete();
        cyc(); rst = 1'b1;
        return;
      end
      mid();
      e = exp_q.pop_front();
      chk("stream_data", 32'(ld_if.inv_data), 32'(e));
    end
    cyc();
    if (poke) begin
      ld_if.start = 1'b1; ld_if.order = 4'd2;
      ld_if.in_valid = 1'b1; ld_if.in_data = 16'h1234;
    end
    mid(); chk("wait_hold_data", 32'(ld_if.inv_data), 32'(last));
           chk("wait_busy", 32'(ld_if.busy), 1);
           chk("wait_timeout", 32'(ld_if.timeout), 0);
    if (rdy_dly < 0) begin
      for (int w = 2; w <= 16; w++) begin
        cyc(); mid();
        chk("wdog_timeout", 32'(ld_if.timeout), (w == 16) ? 1 : 0);
        chk("wdog_busy", 32'(ld_if.busy), 1);
      end
      cyc(); mid(); chk("wdog_after_timeout", 32'(ld_if.timeout), 0);
                    chk("wdog_inv_rst", 32'(ld_if.inv_rst), 0);
                    chk("wdog_busy_low", 32'(ld_if.busy), 0);
                    chk("wdog_no_done", 32'(ld_if.done), 0);
      cyc(); mid(); chk("wdog_inv_rst_back", 32'(ld_if.inv_rst), 1);
      return;
    end
    for (int w = 1; w < rdy_dly; w++) begin
      cyc(); mid();
      chk("wait_in_ready", 32'(ld_if.in_ready), 0);
      chk("wait_busy_hold", 32'(ld_if.busy), 1);
      chk("wait_no_err", 32'(ld_if.err_order), 0);
      chk("wait_no_done", 32'(ld_if.done), 0);
    end
    cyc(); ld_if.start = 1'b0; ld_if.in_valid = 1'b0; ld_if.inv_ready = 1'b1;
    mid(); chk("ready_seen_done", 32'(ld_if.done), 0);
           chk("ready_seen_busy", 32'(ld_if.busy), 1);
    cyc(); ld_if.inv_ready = 1'b0;
    mid(); chk("done_pulse", 32'(ld_if.done), 1);
           chk("done_busy_low", 32'(ld_if.busy), 0);
           chk("done_inv_rst", 32'(ld_if.inv_rst), 1);
    cyc(); mid(); chk("done_cleared", 32'(ld_if.done), 0);
  endtask

  initial begin
    ld_if.start = 1'b0; ld_if.order = 4'd0; ld_if.in_valid = 1'b0;
    ld_if.in_data = '0; ld_if.inv_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    mid(); chk_reset_vals("reset");
    cyc(); rst = 1'b1;
    cyc(); mid(); chk("idle_inv_rst", 32'(ld_if.inv_rst), 1);
                  chk("idle_busy", 32'(ld_if.busy), 0);

    // order 2, in_valid held high
    src[0] = 16'd4; src[1] = 16'd7; src[2] = 16'd2; src[3] = 16'd6;
    run_load(2, 1'b0, 10, -1, 1'b0);

    // order 3, in_valid toggling
    for (int i = 0; i < 9; i++) src[i] = 16'(i + 1);
    run_load(3, 1'b1, 3, -1, 1'b0);

    // illegal order 0 (MAX_ORDER+1 = 16 does not fit in 4 bits)
    cyc(); ld_if.start = 1'b1; ld_if.order = 4'd0;
    cyc(); ld_if.start = 1'b0;
    mid(); chk("err_order_pulse", 32'(ld_if.err_order), 1);
           chk("err_order_busy", 32'(ld_if.busy), 0);
    cyc(); mid(); chk("err_order_clear", 32'(ld_if.err_order), 0);
                  chk("err_order_idle", 32'(ld_if.in_ready), 0);

    // largest order, signed-looking data
    for (int i = 0; i < 225; i++) src[i] = 16'($urandom);
    src[0] = 16'h8000; src[224] = 16'hFFFF;
    run_load(15, 1'b0, 2, -1, 1'b0);

    // reset while element 2 is on inv_data, then a fresh order-1 load
    src[0] = 16'd10; src[1] = 16'd20; src[2] = 16'd30; src[3] = 16'd40;
    run_load(2, 1'b0, 0, 2, 1'b0);
    src[0] = 16'h8001;
    run_load(1, 1'b0, 1, -1, 1'b0);

    // start and in_valid during WAIT are ignored
    src[0] = 16'hFFFF; src[1] = 16'h0001; src[2] = 16'h7FFF; src[3] = 16'h8000;
    run_load(2, 1'b0, 5, -1, 1'b1);

`ifdef MATRIX_LOADER_TIMEOUT_EN
    src[0] = 16'h0042;
    run_load(1, 1'b0, -1, -1, 1'b0);
`endif

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
